mastermind_grader: RTL
======================

MASTERMIND_GRADER -- requirements
Module: mastermind_grader

Interface
REQ-001 The block SHALL have no parameters; peg count (4) and colour count (8) SHALL be package constants.
REQ-002 clock  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 go  input  1  start request; sampled only in IDLE.
REQ-005 guess0..guess3  input  3 each  guessed colour per peg position.
REQ-006 pattern0..pattern3  input  3 each  secret colour per peg position.
REQ-007 red  output  3  count of exact colour-and-position matches (0..4).
REQ-008 white  output  3  count of colour matches in the wrong position (0..4).
REQ-009 done  output  1  one-cycle pulse; red and white are valid.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, RED, WHITE and DONE.
REQ-012 IDLE with go=1 SHALL latch all eight operands, clear both counters and both colour histograms, set index=0, and enter RED.
REQ-013 RED SHALL process one peg per cycle for index 0..3.
- Equal pegs: red increments.
- Unequal pegs: guess histogram[guess] and pattern histogram[pattern] each increment.
- After index 3 the FSM SHALL enter WHITE with index=0.
REQ-014 WHITE SHALL process one colour per cycle for index 0..7, adding min(guess_hist, pattern_hist) to white; after index 7 the FSM SHALL enter DONE.
REQ-015 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-016 Latency: done SHALL be high in the cycle following the 13th rising edge counted from the edge that samples go (4 RED cycles + 8 WHITE cycles).
REQ-017 red and white SHALL hold their values from DONE until the next accepted go.
REQ-018 go while busy=1 SHALL be ignored.
REQ-019 go held high continuously SHALL start a new grading on the cycle after DONE (back-to-back operation).
REQ-020 Operand changes after the go-sampling edge SHALL NOT affect the result.
REQ-021 Width rules:
- Histogram bins SHALL be 3 bits (max 4).
- red + white SHALL never exceed 4.
- No counter SHALL wrap.

Reset
REQ-022 On reset assertion the FSM SHALL enter IDLE immediately, whether or not an operation is in progress.
REQ-023 Reset SHALL set red=0, white=0, done=0, busy=0, index=0, histograms=0 and latched operands=0.
REQ-024 Reset mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-025 With GRADER_EARLY_EXIT_EN defined, red=4 at the end of RED SHALL skip WHITE and enter DONE directly with white=0, giving done after the 5th edge.
REQ-026 Without GRADER_EARLY_EXIT_EN, WHITE SHALL always run all 8 cycles and latency SHALL be fixed per REQ-016.

Structure
REQ-027 Package grader_pkg SHALL hold:
- NUM_PEGS=4 and NUM_COLORS=8
- typedef color_t (3 bits)
- typedef count_t (3 bits)
- the state enum grader_state_t
REQ-028 Sub-module color_histogram SHALL hold the 8x3-bit bin array for one side, with clear, increment-at-colour and read-at-colour ports; two instances SHALL be used (guess side, pattern side).

Verification
REQ-029 Exact match: guess {g3..g0}={2,4,2,5}, pattern={2,4,2,5}, go pulse -> done after 13 edges, red=4, white=0; with GRADER_EARLY_EXIT_EN, done after 5 edges.
REQ-030 All-white: guess g0=2,g1=5,g2=2,g3=4 against pattern p0=5,p1=2,p2=4,p3=2 -> red=0, white=4.
REQ-031 Mixed: guess all 2 against pattern p0=5,p1=2,p2=4,p3=2 -> red=2, white=0. Guess all 0 against the same pattern -> red=0, white=0.
REQ-032 Busy handling: go pulsed during RED and WHITE -> no restart, single done. Go held high -> consecutive results with done every 14 cycles.
REQ-033 Reset mid-operation: reset asserted asynchronously during WHITE index 3 -> immediate IDLE, busy=0, red=0, white=0, no done pulse. A following go grades correctly.
REQ-034 Operand stability: guess changed one cycle after go -> result matches the operands latched at go.

Source files
------------

// File: rtl/grader_pkg.sv
// Shared constants, types and FSM encoding for the Mastermind grader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package grader_pkg;

    localparam int NUM_PEGS   = 4;
    localparam int NUM_COLORS = 8;

    typedef logic [2:0] color_t;
    typedef logic [2:0] count_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RED   = 2'd1,
        S_WHITE = 2'd2,
        S_DONE  = 2'd3
    } grader_state_t;

    // Colour-match contribution of one colour: pegs that can pair up across sides.
    function automatic count_t min_count(input count_t a, input count_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/color_histogram.sv
// Per-colour occurrence counter for one side (guess or pattern) of the grader.
// Latency: increment/clear take effect on the next rising edge; read is combinational.
// Backpressure: none; caller issues at most one increment per cycle.
// Ports: clock/reset (async active-high), clr (zero all bins), inc + inc_color
//        (bump one bin), rd_color -> rd_count (bin value for that colour).
module color_histogram
    import grader_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   clr,
    input  logic   inc,
    input  color_t inc_color,
    input  color_t rd_color,
    output count_t rd_count
);

    count_t bin_q [NUM_COLORS];
    count_t bin_d [NUM_COLORS];

    always_comb begin
        bin_d = bin_q;
        if (clr) begin
            for (int i = 0; i < NUM_COLORS; i++) begin
                bin_d[i] = '0;
            end
        end else if (inc && (bin_q[inc_color] != '1)) begin
            // Saturate rather than wrap; only four pegs exist so the cap is never reached.
            bin_d[inc_color] = bin_q[inc_color] + 3'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COLORS; i++) begin
                bin_q[i] <= '0;
            end
        end else begin
            bin_q <= bin_d;
        end
    end

    assign rd_count = bin_q[rd_color];

endmodule

// File: rtl/mastermind_grader.sv
// Mastermind scorer: counts exact (red) and colour-only (white) matches of a 4-peg guess.
// Latency: done 13 edges after go is sampled (5 when GRADER_EARLY_EXIT_EN and red=4).
// Backpressure: go is only accepted in IDLE; go while busy is ignored.
// Ports: clock, reset (async active-high), go, guess0..3, pattern0..3 (3-bit colours),
//        red/white (3-bit counts, held until next go), done (1-cycle pulse), busy.
// Build option: GRADER_EARLY_EXIT_EN skips the WHITE phase when all four pegs are red.
module mastermind_grader
    import grader_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic [2:0] guess0,
    input  logic [2:0] guess1,
    input  logic [2:0] guess2,
    input  logic [2:0] guess3,
    input  logic [2:0] pattern0,
    input  logic [2:0] pattern1,
    input  logic [2:0] pattern2,
    input  logic [2:0] pattern3,
    output logic [2:0] red,
    output logic [2:0] white,
    output logic       done,
    output logic       busy
);

    grader_state_t state_q, state_d;
    logic [2:0]    index_q, index_d;
    count_t        red_q, red_d;
    count_t        white_q, white_d;
    color_t [NUM_PEGS-1:0] guess_q, guess_d;
    color_t [NUM_PEGS-1:0] pattern_q, pattern_d;

    logic   hist_clr;
    logic   hist_inc;
    color_t guess_cur;
    color_t pattern_cur;
    count_t guess_cnt;
    count_t pattern_cnt;

    // In RED the index selects a peg; in WHITE the same index walks the colours.
    assign guess_cur   = guess_q[index_q[1:0]];
    assign pattern_cur = pattern_q[index_q[1:0]];

    color_histogram u_guess_hist (
        .clock     (clock),
        .reset     (reset),
        .clr       (hist_clr),
        .inc       (hist_inc),
        .inc_color (guess_cur),
        .rd_color  (index_q),
        .rd_count  (guess_cnt)
    );

    color_histogram u_pattern_hist (
        .clock     (clock),
        .reset     (reset),
        .clr       (hist_clr),
        .inc       (hist_inc),
        .inc_color (pattern_cur),
        .rd_color  (index_q),
        .rd_count  (pattern_cnt)
    );

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        red_d     = red_q;
        white_d   = white_q;
        guess_d   = guess_q;
        pattern_d = pattern_q;
        hist_clr  = 1'b0;
        hist_inc  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    guess_d   = {guess3, guess2, guess1, guess0};
                    pattern_d = {pattern3, pattern2, pattern1, pattern0};
                    red_d     = '0;
                    white_d   = '0;
                    hist_clr  = 1'b1;
                    index_d   = '0;
                    state_d   = S_RED;
                end
            end
            S_RED: begin
                // Exact matches are excluded from the histograms so WHITE never double-counts.
                if (guess_cur == pattern_cur) begin
                    red_d = red_q + 3'd1;
                end else begin
                    hist_inc = 1'b1;
                end
                if (index_q == 3'(NUM_PEGS - 1)) begin
                    index_d = '0;
                    state_d = S_WHITE;
`ifdef GRADER_EARLY_EXIT_EN
                    if (red_d == 3'(NUM_PEGS)) begin
                        state_d = S_DONE;
                    end
`endif
                end else begin
                    index_d = index_q + 3'd1;
                end
            end
            S_WHITE: begin
                white_d = white_q + min_count(guess_cnt, pattern_cnt);
                if (index_q == 3'(NUM_COLORS - 1)) begin
                    index_d = '0;
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            red_q     <= '0;
            white_q   <= '0;
            guess_q   <= '0;
            pattern_q <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            red_q     <= red_d;
            white_q   <= white_d;
            guess_q   <= guess_d;
            pattern_q <= pattern_d;
        end
    end

    assign red   = red_q;
    assign white = white_q;
    assign done  = (state_q == S_DONE);
    assign busy  = (state_q != S_IDLE);

endmodule
